uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx serializer among NUM_REQ byte sources (command, status, debug, loopback). Each requester presents a byte with a level request. The arbiter grants one requester, launches the byte on uart_tx, waits for completion, then acknowledges the requester. A watchdog aborts a transfer whose tx_done never arrives, so a wedged transmitter cannot hang every source.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_CLKS_PER_BIT, 16, uart_tx bit period in clk cycles; used only for the timeout default
TIMEOUT_CLKS, 12*NUM_CLKS_PER_BIT, cycles allowed from tx_start to tx_done before abort

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
req  in  NUM_REQ  level request per requester; held until ack
din  in  8*NUM_REQ  byte per requester; requester i uses din[8i+7:8i]; stable while req[i]=1
ack  out  NUM_REQ  one-cycle pulse: byte of requester i consumed (sent or aborted)
err  out  1  one-cycle pulse, coincident with ack, when the transfer timed out
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
tx_start  out  1  one-cycle launch pulse to uart_tx
tx_data  out  8  byte to uart_tx; stable from tx_start until completion
tx_busy  in  1  uart_tx busy from the cycle after tx_start until its stop bit ends
tx_done  in  1  uart_tx one-cycle completion pulse

Behaviour:
- Reset (rstn=0 at a clk edge): ack=0, err=0, tx_start=0, tx_data=0, grant_id=0, timer=0, state=ARB_IDLE, last pointer=NUM_REQ-1 (requester 0 wins the first tie).
- All outputs are registered. The arbiter has no combinational path from req or din to any output.
- States: ARB_IDLE, ARB_START, ARB_WAIT, ARB_ACK. The default branch returns to ARB_IDLE with all pulses low.
- ARB_IDLE:
  - Form the effective request: req with the bit of any requester whose ack is currently high masked off.
  - If the effective request is nonzero and tx_busy=0, pick the first set bit searching last+1, last+2, ... mod NUM_REQ.
  - On a pick: latch grant_id and tx_data=din[grant], then go to ARB_START.
  - Otherwise stay in ARB_IDLE.
- ARB_START:
  - tx_start=1 for exactly this cycle; timer cleared to 0; go to ARB_WAIT.
  - Latency: request sampled at edge N gives tx_start high during cycle N+1.
- ARB_WAIT:
  - timer increments each cycle; width is $clog2(TIMEOUT_CLKS+1), so it never wraps before the compare.
  - If tx_done=1: go to ARB_ACK with err=0.
  - Else if timer==TIMEOUT_CLKS-1: go to ARB_ACK with err=1.
  - If tx_done and the timeout coincide in the same cycle, tx_done wins and err=0.
- ARB_ACK:
  - ack[grant_id]=1 (one-hot, one cycle); err as decided in ARB_WAIT; last pointer=grant_id; go to ARB_IDLE.
  - tx_data is held until the next grant.
- Requester contract:
  - A requester sees ack high during cycle M. By the edge ending M it must drop req or present its next byte.
  - The ack mask in ARB_IDLE guarantees the same byte is never sent twice.
- Round-robin:
  - A requester holding req continuously is served at most once per NUM_REQ grants while others are pending.
  - Worst-case wait before grant: (NUM_REQ-1) full transfers.
- req[i] dropped after grant, before ack: the byte is still sent and ack[i] still pulses.
- tx_busy=1 in ARB_IDLE (external or leftover activity): no grant until it clears.
- A spurious tx_done outside ARB_WAIT is ignored.
- Reset mid-transfer: immediate return to reset values. Any in-flight byte is dropped with no ack; uart_tx shares rstn.
- At most one of tx_start and ack is high in any cycle.

Test Plan:
- Single request: req=4'b0001, din[7:0]=8'hA5, uart_tx model with done 160 clks after start -> tx_start one cycle after req sampled, tx_data=8'hA5, ack=4'b0001 one cycle after tx_done, err=0, grant_id=0.
- All four request simultaneously after reset, bytes 8'h10/8'h21/8'h32/8'h43 -> grant order 0,1,2,3; serial output 10,21,32,43; one ack each; no tx_start while tx_busy=1.
- Fairness: req[0] held continuously with new bytes each ack, req[2] raised mid-transfer of requester 0 -> the next grant goes to 2 before 0 is served again.
- Timeout: model never pulses tx_done, TIMEOUT_CLKS=192 -> ack and err pulse together 192 cycles after ARB_WAIT entry; arbiter returns to ARB_IDLE and serves the next requester.
- Boundary: tx_done arrives on the final timeout cycle -> err=0, normal ack. req[1] dropped after grant -> byte still sent, ack[1] still pulses.
- Reset mid-transfer: rstn=0 for 1 cycle during ARB_WAIT -> all outputs at reset values the next cycle, no ack. A following req=4'b0100 is granted normally (requester 2 is first in order from last=3).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among NUM_REQ byte sources,
// with a watchdog that aborts a transfer whose tx_done never arrives.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned NUM_CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_CLKS     = 12 * NUM_CLKS_PER_BIT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       din,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_e;

  arb_state_e           state;
  arb_state_e           state_nxt;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        timer_nxt;
  logic [GW-1:0]        last;
  logic [GW-1:0]        last_nxt;
  logic [NUM_REQ-1:0]   eff_req;
  logic                 pick_vld;
  logic [GW-1:0]        pick_idx;
  logic                 launch;
  logic                 tmo;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic                 err_nxt;
  logic                 tx_start_nxt;
  logic [7:0]           tx_data_nxt;
  logic [GW-1:0]        grant_id_nxt;

  // Round-robin search starting just after the last served requester
  always_comb begin
    eff_req  = req & ~ack;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      logic [GW-1:0] cand;
      cand = GW'((32'(last) + k) % NUM_REQ);
      if (!pick_vld && eff_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign launch = pick_vld && !tx_busy;
  assign tmo    = (timer == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (launch) state_nxt = ARB_START;
      ARB_START: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (tx_done || tmo) state_nxt = ARB_ACK;
      ARB_ACK:   state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs; tx_done beats a coincident timeout
  always_comb begin
    ack_nxt      = '0;
    err_nxt      = 1'b0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    grant_id_nxt = grant_id;
    timer_nxt    = timer;
    last_nxt     = last;
    case (state)
      ARB_IDLE: begin
        if (launch) begin
          grant_id_nxt = pick_idx;
          tx_data_nxt  = din[8*pick_idx +: 8];
          tx_start_nxt = 1'b1;
        end
      end
      ARB_START: timer_nxt = '0;
      ARB_WAIT: begin
        timer_nxt = timer + TW'(1);
        if (tx_done) begin
          ack_nxt = NUM_REQ'(1) << grant_id;
        end else if (tmo) begin
          ack_nxt = NUM_REQ'(1) << grant_id;
          err_nxt = 1'b1;
        end
      end
      ARB_ACK:  last_nxt = grant_id;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ack      <= '0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      timer    <= '0;
      last     <= GW'(NUM_REQ - 1);
    end else begin
      ack      <= ack_nxt;
      err      <= err_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      grant_id <= grant_id_nxt;
      timer    <= timer_nxt;
      last     <= last_nxt;
    end
  end

endmodule
